// File: rtl/decode_issue.sv
// Bundle decoder with dependency-aware issue grouping. Optional macro
// DECODE_ISSUE_SPLIT_EN enables intra-bundle dependency splitting and o_split_cnt.
module decode_issue #(
  parameter int LANES = 2,
  parameter int CNT_W = 16,
  localparam int DEC_W = 55
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*32-1:0]    i_insts,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*DEC_W-1:0] o_decode,
  output logic [LANES-1:0]       o_lane_valid,
  output logic [LANES-1:0]       o_illegal,
  output logic [CNT_W-1:0]       o_split_cnt
);

  // Per-lane decode word, LSB first: alu_op[2:0], alu_src, reg_write, mem_to_reg,
  // mem_read, mem_write, dst[4:0], src0[4:0], src1[4:0], imm[31:0].
  localparam int F_RW  = 4;
  localparam int F_DST = 8;
  localparam int F_S0  = 13;
  localparam int F_S1  = 18;

  typedef enum logic {RUN, SPLIT} state_t;

  state_t                       state_q, state_d;
  logic                         valid_q, valid_d;
  logic [LANES-1:0][DEC_W-1:0]  bundle_q, bundle_d, new_dec;
  logic [LANES-1:0]             ill_q, ill_d, new_ill;
  logic [LANES-1:0]             lane_valid_q, lane_valid_d;
  logic [LANES-1:0]             pending_q, pending_d;
  logic [LANES-1:0]             grp_pend, grp_mask;
  logic                         accept, consume;

  function automatic logic [DEC_W:0] decode_inst(input logic [31:0] inst);
    logic [2:0]  alu_op;
    logic        alu_src, rw, m2r, mr, mw, ill;
    logic [4:0]  dst, s0, s1;
    logic [31:0] imm;
    alu_op = 3'b000;
    alu_src = 1'b0;
    rw = 1'b0;
    m2r = 1'b0;
    mr = 1'b0;
    mw = 1'b0;
    ill = 1'b0;
    dst = inst[11:7];
    s0 = inst[19:15];
    s1 = 5'd0;
    imm = 32'd0;
    case (inst[6:0])
      7'b0110011: begin
        s1 = inst[24:20];
        rw = 1'b1;
        m2r = 1'b1;
        case ({inst[31:25], inst[14:12]})
          10'b0000000_000: alu_op = 3'b001;
          10'b0100000_000: alu_op = 3'b010;
          10'b0000000_100: alu_op = 3'b011;
          10'b0100000_101: alu_op = 3'b101;
          default:         ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        alu_src = 1'b1;
        rw = 1'b1;
        m2r = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
        case (inst[14:12])
          3'b000:  alu_op = 3'b001;
          3'b111:  alu_op = 3'b100;
          default: ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        alu_op = 3'b001;
        alu_src = 1'b1;
        rw = 1'b1;
        mr = 1'b1;
        imm = {{20{inst[31]}}, inst[31:20]};
        ill = (inst[14:12] != 3'b010);
      end
      7'b0100011: begin
        alu_op = 3'b001;
        alu_src = 1'b1;
        mw = 1'b1;
        dst = 5'd0;
        s1 = inst[24:20];
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill = (inst[14:12] != 3'b010);
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      decode_inst = '0;
      decode_inst[DEC_W] = 1'b1;
    end else begin
      decode_inst = {1'b0, imm, s1, s0, dst, mw, mr, m2r, rw, alu_src, alu_op};
    end
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      {new_ill[l], new_dec[l]} = decode_inst(i_insts[l*32 +: 32]);
    end
  end

  assign o_ready = (state_q == RUN) & ~i_flush & (~valid_q | i_ready);
  assign accept  = i_valid & o_ready;
  assign consume = valid_q & i_ready;

  // In RUN the group is formed from the incoming bundle; in SPLIT from what remains.
  assign grp_pend = (state_q == SPLIT) ? pending_q : '1;

`ifdef DECODE_ISSUE_SPLIT_EN
  logic [LANES-1:0][DEC_W-1:0] grp_dec;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  assign grp_dec = (state_q == SPLIT) ? bundle_q : new_dec;

  always_comb begin
    logic stop, dep;
    grp_mask = '0;
    stop = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      dep = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (grp_mask[j] && grp_dec[j][F_RW] && (grp_dec[j][F_DST +: 5] != 5'd0) &&
            ((grp_dec[j][F_DST +: 5] == grp_dec[k][F_S0 +: 5]) ||
             (grp_dec[j][F_DST +: 5] == grp_dec[k][F_S1 +: 5])))
          dep = 1'b1;
      end
      if (grp_pend[k] && !stop) begin
        if (dep) stop = 1'b1;
        else     grp_mask[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_split_cnt = cnt_q;
`else
  assign grp_mask    = grp_pend;
  assign o_split_cnt = '0;
`endif

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    bundle_d     = bundle_q;
    ill_d        = ill_q;
    lane_valid_d = lane_valid_q;
    pending_d    = pending_q;
`ifdef DECODE_ISSUE_SPLIT_EN
    cnt_d        = cnt_q;
`endif
    if (i_flush) begin
      state_d      = RUN;
      valid_d      = 1'b0;
      lane_valid_d = '0;
      pending_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            bundle_d     = new_dec;
            ill_d        = new_ill;
            valid_d      = 1'b1;
            lane_valid_d = grp_mask;
            pending_d    = ~grp_mask;
            if (grp_mask != '1) begin
              state_d = SPLIT;
`ifdef DECODE_ISSUE_SPLIT_EN
              if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
            end
          end else if (consume) begin
            valid_d      = 1'b0;
            lane_valid_d = '0;
          end
        end
        SPLIT: begin
          if (consume) begin
            lane_valid_d = grp_mask;
            pending_d    = pending_q & ~grp_mask;
            if ((pending_q & ~grp_mask) == '0) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= RUN;
      valid_q      <= 1'b0;
      bundle_q     <= '0;
      ill_q        <= '0;
      lane_valid_q <= '0;
      pending_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      bundle_q     <= bundle_d;
      ill_q        <= ill_d;
      lane_valid_q <= lane_valid_d;
      pending_q    <= pending_d;
    end
  end

  // Lanes not issued in the current group present an all-zero decode.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      o_decode[l*DEC_W +: DEC_W] = lane_valid_q[l] ? bundle_q[l] : '0;
    end
  end

  assign o_valid      = valid_q;
  assign o_lane_valid = lane_valid_q;
  assign o_illegal    = ill_q & lane_valid_q;

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning instructions per bundle (range 1..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning split-event counter width.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 SHALL have port i_flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port i_valid  input  1  upstream bundle valid.
REQ-007 SHALL have port o_ready  output  1  bundle accepted when i_valid & o_ready.
REQ-008 SHALL have port i_insts  input  LANES x word  bundle; lane 0 oldest.
REQ-009 SHALL have port o_valid  output  1  decoded group valid.
REQ-010 SHALL have port i_ready  input  1  downstream consumes when o_valid & i_ready.
REQ-011 SHALL have port o_decode  output  LANES x decode_struct  per-lane decode.
REQ-012 SHALL have port o_lane_valid  output  LANES  lanes issued in current group.
REQ-013 SHALL have port o_illegal  output  LANES  lane opcode/funct unsupported.
REQ-014 SHALL have port o_split_cnt  output  CNT_W  bundles that needed more than one group.

Function
REQ-015 Decode: R-type ADD->ALUOp 001, SUB 010, XOR 011, SRA 101; ALUSrc 0, RegWrite 1, MemtoReg 1.
REQ-016 Decode: ADDI->001, ANDI->100; LW->001, MemRead 1, MemtoReg 0; SW->001, MemWrite 1, RegWrite 0, Dst 0.
REQ-017 Immediate: I-type inst[31:20], S-type {inst[31:25],inst[11:7]}, sign-extended to 32 bits; R-type 0.
REQ-018 Unsupported opcode or funct: all decode fields 0, o_illegal lane bit 1; lane still issued, never a dependency source.
REQ-019 Latency: accepted bundle's first group appears at o_valid on the next edge.
REQ-020 o_ready = RUN state & !i_flush & (!o_valid | i_ready).
REQ-021 While o_valid & !i_ready, all outputs hold stable.
REQ-022 Dependency: lane k depends on earlier lane j in same group if j RegWrite=1, j Dst!=0, and Dst equals k Src0 or (R/S-type only) k Src1.
REQ-023 Group: from lowest pending lane upward, stop before first dependent lane; lanes keep positions, unissued lanes 0 in o_lane_valid.
REQ-024 FSM RUN: accept; group covers all lanes -> stay RUN, else load group, store pending mask, go SPLIT, o_split_cnt +1 (saturating).
REQ-025 FSM SPLIT: on consume, load next group from pending; pending empty after load -> RUN.
REQ-026 LANES=1: never splits; o_split_cnt stays 0.
REQ-027 i_flush highest priority: next edge o_valid=0, o_lane_valid=0, pending cleared, state RUN, no bundle accepted that cycle; o_split_cnt kept.

Reset
REQ-028 On i_rst_n low, immediately: o_valid 0, o_decode all 0, o_lane_valid 0, o_illegal 0, o_split_cnt 0, state RUN, pending 0.
REQ-029 Reset mid-SPLIT discards remaining lanes; none issued after release.
REQ-030 o_ready SHALL be 1 in the first cycle after reset release if i_flush=0.

Configuration
REQ-031 Macro DECODE_ISSUE_SPLIT_EN defined: dependency split and o_split_cnt per REQ-022..026.
REQ-032 Macro undefined: no dependency check, whole bundle issued in one group, FSM stays RUN, o_split_cnt tied 0.

Verification
REQ-033 LANES=2, 0x002081B3 / 0x00720293 -> next cycle o_valid 1, o_lane_valid 11, ALUOp 001/001, lane1 immediate 7.
REQ-034 0x00100293 / 0x00528333, i_ready 1 -> cycle1 o_lane_valid 01, o_ready 0; cycle2 10; o_split_cnt 1 (macro off: 11 in cycle1, cnt 0).
REQ-035 Lane0 SW 0xFE20AE23 -> immediate 0xFFFFFFFC, MemWrite 1, RegWrite 0; lane1 0xFFFFFFFF -> o_illegal 10, lane1 fields 0.
REQ-036 i_ready 0 for 3 cycles after valid group -> o_decode/o_lane_valid unchanged, o_ready 0.
REQ-037 i_flush during SPLIT of REQ-034 bundle -> next cycle o_valid 0, o_ready 1; lane1 never issued.
REQ-038 i_rst_n low mid-SPLIT, asynchronous -> outputs 0 before next edge; after release o_ready 1, o_split_cnt 0.
